// File: rtl/spcpu_mem_bus_arbiter_if.sv
// Shared CPU memory bus bundle: fetch and load/store requester ports plus
// the single memory-side address/data path.
interface spcpu_mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_grant;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;

  logic              ds_req;
  logic [ADDR_W-1:0] ds_addr;
  logic              ds_we;
  logic              ds_sz;
  logic [DATA_W-1:0] ds_wdata;
  logic              ds_grant;
  logic              ds_done;
  logic [DATA_W-1:0] ds_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_acc_sz;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  if_req, if_addr, ds_req, ds_addr, ds_we, ds_sz, ds_wdata, mem_rdata,
    output if_grant, if_done, if_rdata, ds_grant, ds_done, ds_rdata,
           mem_addr, mem_acc_sz, mem_we, mem_wdata
  );

  // Requester / memory view
  modport master (
    output if_req, if_addr, ds_req, ds_addr, ds_we, ds_sz, ds_wdata, mem_rdata,
    input  if_grant, if_done, if_rdata, ds_grant, ds_done, ds_rdata,
           mem_addr, mem_acc_sz, mem_we, mem_wdata
  );
endinterface

// File: rtl/spcpu_mem_bus_arbiter.sv
// Two-requester memory bus arbiter: one access at a time, fixed latency,
// data-first priority with a bounded-starvation guard for instruction fetch.
module spcpu_mem_bus_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned MAX_SKIP = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  spcpu_mem_bus_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W  = (MEM_LAT < 2)  ? 1 : $clog2(MEM_LAT);
  localparam int unsigned SKIP_W = (MAX_SKIP < 1) ? 1 : $clog2(MAX_SKIP + 1);
  localparam logic [SKIP_W-1:0] SKIP_MAX = SKIP_W'(MAX_SKIP);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [SKIP_W-1:0]   r_skip;
  logic                r_owner_ds;

  logic                r_if_grant;
  logic                r_if_done;
  logic [DATA_W-1:0]   r_if_rdata;
  logic                r_ds_grant;
  logic                r_ds_done;
  logic [DATA_W-1:0]   r_ds_rdata;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_acc_sz;
  logic                r_mem_we;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic                w_fetch_wins;
  logic [SKIP_W-1:0]   w_skip_inc;
  logic [DATA_W-1:0]   w_rdata_fmt;

  // Fetch only overtakes data once it has been passed over MAX_SKIP times
  assign w_fetch_wins = bus.if_req && (!bus.ds_req || (r_skip == SKIP_MAX));
  assign w_skip_inc   = (r_skip == SKIP_MAX) ? r_skip : r_skip + SKIP_W'(1);
  assign w_rdata_fmt  = r_mem_acc_sz ? bus.mem_rdata
                                     : {{(DATA_W-8){1'b0}}, bus.mem_rdata[7:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_skip       <= '0;
      r_owner_ds   <= 1'b0;
      r_if_grant   <= 1'b0;
      r_if_done    <= 1'b0;
      r_if_rdata   <= '0;
      r_ds_grant   <= 1'b0;
      r_ds_done    <= 1'b0;
      r_ds_rdata   <= '0;
      r_mem_addr   <= '0;
      r_mem_acc_sz <= 1'b1;
      r_mem_we     <= 1'b0;
      r_mem_wdata  <= '0;
    end else begin
      r_if_grant <= 1'b0;
      r_ds_grant <= 1'b0;
      r_if_done  <= 1'b0;
      r_ds_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.if_req || bus.ds_req) begin
            r_state <= S_BUSY;
            r_cnt   <= CNT_W'(MEM_LAT - 1);
            if (w_fetch_wins) begin
              r_owner_ds   <= 1'b0;
              r_if_grant   <= 1'b1;
              r_mem_addr   <= bus.if_addr;
              r_mem_we     <= 1'b0;
              r_mem_acc_sz <= 1'b1;
              r_skip       <= '0;
            end else begin
              r_owner_ds   <= 1'b1;
              r_ds_grant   <= 1'b1;
              r_mem_addr   <= bus.ds_addr;
              r_mem_we     <= bus.ds_we;
              r_mem_acc_sz <= bus.ds_sz;
              r_mem_wdata  <= bus.ds_wdata;
              if (bus.if_req) begin
                r_skip <= w_skip_inc;
              end
            end
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            if (r_owner_ds) begin
              r_ds_done <= 1'b1;
              if (!r_mem_we) begin
                r_ds_rdata <= w_rdata_fmt;
              end
            end else begin
              r_if_done  <= 1'b1;
              r_if_rdata <= w_rdata_fmt;
            end
            // Bus returns to its parked read/16-bit state; address holds
            r_mem_we     <= 1'b0;
            r_mem_acc_sz <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.if_grant   = r_if_grant;
  assign bus.if_done    = r_if_done;
  assign bus.if_rdata   = r_if_rdata;
  assign bus.ds_grant   = r_ds_grant;
  assign bus.ds_done    = r_ds_done;
  assign bus.ds_rdata   = r_ds_rdata;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_acc_sz = r_mem_acc_sz;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_spcpu_mem_bus_arbiter.sv
// Scoreboard bench for spcpu_mem_bus_arbiter: directed scenarios followed by
// randomized request slots, checked against a transaction-level model.
module tb_spcpu_mem_bus_arbiter;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned MEM_LAT  = 3;
  localparam int unsigned MAX_SKIP = 3;

  typedef struct {
    bit          is_ds;
    logic [15:0] addr;
    bit          we;
    bit          sz;
    logic [15:0] wdata;
    int unsigned cyc;
  } grant_t;

  typedef struct {
    bit          is_ds;
    logic [15:0] if_rd;
    logic [15:0] ds_rd;
    int unsigned cyc;
  } done_t;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int          vectors = 0;
  int          errors  = 0;

  grant_t      gq[$];
  done_t       dq[$];
  grant_t      mon_g;
  done_t       mon_d;

  int unsigned skip_m  = 0;
  logic [15:0] if_rd_m = '0;
  logic [15:0] ds_rd_m = '0;

  spcpu_mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  spcpu_mem_bus_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MEM_LAT (MEM_LAT),
    .MAX_SKIP(MAX_SKIP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT pulses a grant or done
  always @(negedge clk) begin
    if (bus.if_grant === 1'b1 || bus.ds_grant === 1'b1) begin
      if (gq.size() == 0) begin
        chk("unexpected_grant", 32'({bus.if_grant, bus.ds_grant}), 32'd0);
      end else begin
        mon_g = gq.pop_front();
        chk("grant_who", 32'({bus.if_grant, bus.ds_grant}), mon_g.is_ds ? 32'd1 : 32'd2);
        chk("grant_cycle", cyc, mon_g.cyc);
        chk("grant_mem_addr", 32'(bus.mem_addr), 32'(mon_g.addr));
        chk("grant_mem_we", 32'(bus.mem_we), 32'(mon_g.we));
        chk("grant_mem_acc_sz", 32'(bus.mem_acc_sz), 32'(mon_g.sz));
        if (mon_g.we) chk("grant_mem_wdata", 32'(bus.mem_wdata), 32'(mon_g.wdata));
      end
    end
    if (bus.if_done === 1'b1 || bus.ds_done === 1'b1) begin
      if (dq.size() == 0) begin
        chk("unexpected_done", 32'({bus.if_done, bus.ds_done}), 32'd0);
      end else begin
        mon_d = dq.pop_front();
        chk("done_who", 32'({bus.if_done, bus.ds_done}), mon_d.is_ds ? 32'd1 : 32'd2);
        chk("done_cycle", cyc, mon_d.cyc);
        chk("if_rdata", 32'(bus.if_rdata), 32'(mon_d.if_rd));
        chk("ds_rdata", 32'(bus.ds_rdata), 32'(mon_d.ds_rd));
        chk("bus_parked", 32'({bus.mem_we, bus.mem_acc_sz}), 32'd1);
      end
    end
  end

  // One request slot, driven at a negedge while the arbiter is idle
  task automatic slot(input bit ifr, input logic [15:0] ifa, input bit dsr,
                      input logic [15:0] dsa, input bit we, input bit sz,
                      input logic [15:0] wd, input logic [15:0] rd, input bit rst_mid);
    grant_t      g;
    done_t       d;
    bit          fw;
    int unsigned k;
    bus.if_req    = ifr;
    bus.if_addr   = ifa;
    bus.ds_req    = dsr;
    bus.ds_addr   = dsa;
    bus.ds_we     = we;
    bus.ds_sz     = sz;
    bus.ds_wdata  = wd;
    bus.mem_rdata = ~rd;
    if (!ifr && !dsr) begin
      @(negedge clk);
      return;
    end
    k  = cyc + 1;
    fw = ifr && (!dsr || skip_m == MAX_SKIP);
    g.is_ds = !fw;
    g.addr  = fw ? ifa : dsa;
    g.we    = fw ? 1'b0 : we;
    g.sz    = fw ? 1'b1 : sz;
    g.wdata = wd;
    g.cyc   = k;
    if (fw) skip_m = 0;
    else if (ifr && skip_m < MAX_SKIP) skip_m++;
    gq.push_back(g);
    @(negedge clk);
    // Request fields are free to change once accepted
    bus.if_addr  = 16'($urandom);
    bus.ds_addr  = 16'($urandom);
    bus.ds_wdata = 16'($urandom);
    bus.ds_we    = 1'($urandom);
    bus.ds_sz    = 1'($urandom);
    if (rst_mid) begin
      reset = 1'b1;
      @(negedge clk);
      chk("reset_pulses_bus", 32'({bus.if_grant, bus.if_done, bus.ds_grant, bus.ds_done,
                                   bus.mem_we, bus.mem_acc_sz}), 32'd1);
      chk("reset_addr_ifrd", {bus.mem_addr, bus.if_rdata}, 32'd0);
      chk("reset_dsrd_wdata", {bus.ds_rdata, bus.mem_wdata}, 32'd0);
      skip_m      = 0;
      if_rd_m     = '0;
      ds_rd_m     = '0;
      bus.if_req  = 1'b0;
      bus.ds_req  = 1'b0;
      reset       = 1'b0;
      return;
    end
    if (fw) if_rd_m = rd;
    else if (!we) ds_rd_m = sz ? rd : {8'h00, rd[7:0]};
    d.is_ds = !fw;
    d.if_rd = if_rd_m;
    d.ds_rd = ds_rd_m;
    d.cyc   = k + MEM_LAT;
    dq.push_back(d);
    for (int i = 0; i < int'(MEM_LAT); i++) begin
      chk("busy_mem_addr", 32'(bus.mem_addr), 32'(g.addr));
      chk("busy_mem_we", 32'(bus.mem_we), 32'(g.we));
      if (g.we) chk("busy_mem_wdata", 32'(bus.mem_wdata), 32'(g.wdata));
      bus.mem_rdata = (i == int'(MEM_LAT) - 1) ? rd : ~rd;
      @(negedge clk);
    end
    bus.mem_rdata = ~rd;
  endtask

  initial begin
    bit          ifr, dsr, rst;
    reset         = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.ds_req    = 1'b0;
    bus.ds_addr   = '0;
    bus.ds_we     = 1'b0;
    bus.ds_sz     = 1'b0;
    bus.ds_wdata  = '0;
    bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("init_pulses_bus", 32'({bus.if_grant, bus.if_done, bus.ds_grant, bus.ds_done,
                                bus.mem_we, bus.mem_acc_sz}), 32'd1);
    chk("init_addr_ifrd", {bus.mem_addr, bus.if_rdata}, 32'd0);
    bus.if_req = 1'b1;
    bus.ds_req = 1'b1;
    @(negedge clk);
    bus.if_req = 1'b0;
    bus.ds_req = 1'b0;
    reset      = 1'b0;
    @(negedge clk);

    // Fetch only, 8-bit data read, data write
    slot(1'b1, 16'h0004, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'hA1B2, 1'b0);
    slot(1'b0, 16'h0000, 1'b1, 16'h0011, 1'b0, 1'b0, 16'h0000, 16'h55CC, 1'b0);
    slot(1'b0, 16'h0000, 1'b1, 16'h0020, 1'b1, 1'b1, 16'hBEEF, 16'h1234, 1'b0);
    // Simultaneous requests with no history: data first, then held fetch
    slot(1'b1, 16'h0100, 1'b1, 16'h0200, 1'b0, 1'b1, 16'h0000, 16'h3C3C, 1'b0);
    slot(1'b1, 16'h0100, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h4D4D, 1'b0);
    // Continuous contention: starvation guard
    for (int i = 0; i < 10; i++)
      slot(1'b1, 16'(16'h1000 + i), 1'b1, 16'(16'h2000 + i), 1'(i % 2), 1'b1,
           16'($urandom), 16'($urandom), 1'b0);
    // Reset during an access, then a normal fetch
    slot(1'b0, 16'h0000, 1'b1, 16'h0030, 1'b0, 1'b1, 16'h0000, 16'h7777, 1'b1);
    slot(1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h8888, 1'b0);

    for (int n = 0; n < 250; n++) begin
      ifr = ($urandom_range(0, 3) != 0);
      dsr = ($urandom_range(0, 3) != 0);
      rst = (ifr || dsr) && ($urandom_range(0, 39) == 0);
      slot(ifr, 16'($urandom), dsr, 16'($urandom), 1'($urandom), 1'($urandom),
           16'($urandom), 16'($urandom), rst);
    end

    bus.if_req = 1'b0;
    bus.ds_req = 1'b0;
    repeat (MEM_LAT + 2) @(negedge clk);
    chk("grant_queue_drained", 32'(gq.size()), 32'd0);
    chk("done_queue_drained", 32'(dq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
